// File: rtl/kbd_event_fifo_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg -- shared types and constants for the keyboard event FIFO.
//
// Contents:
//   kbd_state_e   prefix decoder states (IDLE, EXT, BRK, EXT_BRK, SKIP)
//   PFX_EXT       8'hE0 extended-key prefix
//   PFX_BRK       8'hF0 key-release (break) prefix
//   PFX_PAUSE     8'hE1 Pause/Break sequence prefix
//   PAUSE_SKIP_LEN number of bytes following E1 that are discarded
//   kbd_event_t   10-bit queued event {ext, brk, code}
// ---------------------------------------------------------------------------
package kbd_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EXT     = 3'd1,
      BRK     = 3'd2,
      EXT_BRK = 3'd3,
      SKIP    = 3'd4
   } kbd_state_e;

   localparam logic [7:0] PFX_EXT        = 8'hE0;
   localparam logic [7:0] PFX_BRK        = 8'hF0;
   localparam logic [7:0] PFX_PAUSE      = 8'hE1;
   localparam int         PAUSE_SKIP_LEN = 7;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } kbd_event_t;

   localparam int EV_W = $bits(kbd_event_t);

endpackage

// File: rtl/kbd_event_fifo_if.sv
// ---------------------------------------------------------------------------
// kbd_event_fifo_if -- bus bundle between the PS/2 receiver / CPU side and
// the keyboard event FIFO.
//
// Signals:
//   code_tick, code   byte strobe and scancode byte from ps2_rx
//   rd_en, ovf_clr    CPU pop request and sticky-overflow clear
//   ev_valid, ev_code, ev_break, ev_ext   head event (first-word-fall-through)
//   count, ovf        fill level and sticky overflow flag
//
// Modports: master drives the inputs of the FIFO (testbench / system side),
//           slave is the FIFO itself.
// ---------------------------------------------------------------------------
interface kbd_event_fifo_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          code_tick;
   logic [7:0]    code;
   logic          rd_en;
   logic          ovf_clr;
   logic          ev_valid;
   logic [7:0]    ev_code;
   logic          ev_break;
   logic          ev_ext;
   logic [CW-1:0] count;
   logic          ovf;

   modport master (
      output code_tick, code, rd_en, ovf_clr,
      input  ev_valid, ev_code, ev_break, ev_ext, count, ovf
   );

   modport slave (
      input  code_tick, code, rd_en, ovf_clr,
      output ev_valid, ev_code, ev_break, ev_ext, count, ovf
   );

endinterface

// File: rtl/kbd_event_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock first-word-fall-through FIFO.
//
// Parameters: WIDTH data width, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, wr_data  push request and data
//   rd_en           pop request (ignored while empty)
//   rd_data         head entry, forced to zero while empty
//   full, empty     status
//   count           number of stored entries (0..DEPTH)
//   drop            one-cycle pulse: a push was rejected because full
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   always_comb begin
      pop_ok   = rd_en && !empty;
      // the slot freed by a simultaneous pop makes room for the push
      push_ok  = wr_en && (!full || pop_ok);
      drop     = wr_en && full && !pop_ok;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // pointers are exactly AW bits wide, so they wrap modulo DEPTH
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: stale contents are hidden by the empty gate
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/kbd_event_fifo.sv
// ---------------------------------------------------------------------------
// kbd_event_fifo -- PS/2 scancode prefix decoder feeding an event FIFO.
//
// Bytes arriving with code_tick are decoded: E0 marks an extended key,
// F0 a key release, E1 starts the Pause sequence whose following seven
// bytes are swallowed. Each completed key produces one {ext,brk,code}
// event that is queued for the CPU, which reads it first-word-fall-through.
// A push into a full FIFO (with no pop that cycle) drops the event and sets
// the sticky ovf flag until ovf_clr.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    kbd_event_fifo_if.slave (code_tick/code/rd_en/ovf_clr in,
//          ev_valid/ev_code/ev_break/ev_ext/count/ovf out)
//
// Build option: define KBD_TYPEMATIC_FILTER_EN to drop auto-repeat makes
// (same {code,ext} as the last queued make with no release in between).
// ---------------------------------------------------------------------------
module kbd_event_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   kbd_event_fifo_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   kbd_state_e  state_q, state_d;
   logic [2:0]  skip_cnt_q, skip_cnt_d;
   logic        dec_push;
   kbd_event_t  dec_ev;
   logic        push;
   logic        fifo_drop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [EV_W-1:0] fifo_rd_data;
   kbd_event_t  head;
   logic        ovf_q, ovf_d;

   // ---------------- prefix decoder ----------------
   always_comb begin
      state_d    = state_q;
      skip_cnt_d = skip_cnt_q;
      dec_push   = 1'b0;
      dec_ev     = '0;
      if (bus.code_tick) begin
         case (state_q)
            IDLE: begin
               if (bus.code == PFX_EXT) begin
                  state_d = EXT;
               end else if (bus.code == PFX_BRK) begin
                  state_d = BRK;
               end else if (bus.code == PFX_PAUSE) begin
                  state_d    = SKIP;
                  skip_cnt_d = '0;
               end else begin
                  dec_push    = 1'b1;
                  dec_ev.code = bus.code;
               end
            end
            EXT: begin
               if (bus.code == PFX_BRK) begin
                  state_d = EXT_BRK;
               end else if (bus.code == PFX_EXT) begin
                  state_d = EXT;
               end else begin
                  dec_push    = 1'b1;
                  dec_ev.ext  = 1'b1;
                  dec_ev.code = bus.code;
                  state_d     = IDLE;
               end
            end
            BRK: begin
               dec_push    = 1'b1;
               dec_ev.brk  = 1'b1;
               dec_ev.code = bus.code;
               state_d     = IDLE;
            end
            EXT_BRK: begin
               dec_push    = 1'b1;
               dec_ev.ext  = 1'b1;
               dec_ev.brk  = 1'b1;
               dec_ev.code = bus.code;
               state_d     = IDLE;
            end
            SKIP: begin
               // counter holds the number of bytes already discarded
               if (skip_cnt_q == 3'(PAUSE_SKIP_LEN - 1)) begin
                  skip_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  skip_cnt_d = skip_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d    = IDLE;
               skip_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         skip_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         skip_cnt_q <= skip_cnt_d;
      end
   end

   // ---------------- auto-repeat filter ----------------
`ifdef KBD_TYPEMATIC_FILTER_EN
   logic       trk_valid_q, trk_valid_d;
   logic [8:0] trk_key_q, trk_key_d;
   logic       key_match;
   logic       is_repeat;

   always_comb begin
      trk_valid_d = trk_valid_q;
      trk_key_d   = trk_key_q;
      key_match   = trk_valid_q && (trk_key_q == {dec_ev.ext, dec_ev.code});
      is_repeat   = dec_push && !dec_ev.brk && key_match;
      if (dec_push) begin
         if (dec_ev.brk) begin
            // releasing the tracked key re-arms it; other releases do not
            if (key_match) begin
               trk_valid_d = 1'b0;
            end
         end else if (!is_repeat) begin
            trk_valid_d = 1'b1;
            trk_key_d   = {dec_ev.ext, dec_ev.code};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trk_valid_q <= 1'b0;
         trk_key_q   <= '0;
      end else begin
         trk_valid_q <= trk_valid_d;
         trk_key_q   <= trk_key_d;
      end
   end

   assign push = dec_push && !is_repeat;
`else
   assign push = dec_push;
`endif

   // ---------------- storage ----------------
   sync_fifo #(
      .WIDTH (EV_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .wr_en   (push),
      .wr_data (dec_ev),
      .rd_en   (bus.rd_en),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count),
      .drop    (fifo_drop)
   );

   // a drop wins over a coincident clear so no overflow goes unreported
   always_comb begin
      ovf_d = ovf_q;
      if (fifo_drop) begin
         ovf_d = 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign head         = fifo_rd_data;
   assign bus.ev_valid = !fifo_empty;
   assign bus.ev_code  = head.code;
   assign bus.ev_break = head.brk;
   assign bus.ev_ext   = head.ext;
   assign bus.count    = fifo_count;
   assign bus.ovf      = ovf_q;

   // full status is implied by count; kept for readability of the instance
   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: doc/kbd_event_fifo.md
KBD_EVENT_FIFO -- requirements
Module: kbd_event_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning event FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  system clock (50 MHz domain shared with ps2_rx and cpu).
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port code_tick  input  1  one-cycle pulse from ps2_rx; a new byte is present on code.
REQ-005 SHALL have port code  input  8  received scancode byte; sampled only when code_tick=1.
REQ-006 SHALL have port rd_en  input  1  cpu pop request for the head event.
REQ-007 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port ev_valid  output  1  FIFO non-empty; head event is valid.
REQ-009 SHALL have port ev_code  output  8  head event key code (prefixes stripped).
REQ-010 SHALL have port ev_break  output  1  head event is a key release.
REQ-011 SHALL have port ev_ext  output  1  head event carried the E0 prefix.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current number of stored events.
REQ-013 SHALL have port ovf  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-014 SHALL run a prefix decoder FSM with states IDLE, EXT, BRK, EXT_BRK, SKIP.
REQ-015 On tick in IDLE: E0->EXT, F0->BRK, E1->SKIP, other->push {code,break=0,ext=0}, stay IDLE.
REQ-016 On tick in EXT: F0->EXT_BRK, E0->EXT (repeated prefix ignored), other->push {code,0,1}, go IDLE.
REQ-017 On tick in BRK: push {code,1,0} and go IDLE; in EXT_BRK: push {code,1,1} and go IDLE.
REQ-018 SKIP SHALL discard the next 7 bytes of the Pause sequence with a 3-bit counter, then go IDLE; no event is pushed.
REQ-019 Without code_tick, the FSM SHALL hold its state; there is no timeout.
REQ-020 A push SHALL occur in the cycle of the final byte's tick; ev_valid/count SHALL reflect it on the next clock edge.
REQ-021 Reads SHALL be first-word-fall-through: ev_code/ev_break/ev_ext show the head whenever ev_valid=1; rd_en with ev_valid=1 pops at the clock edge.
REQ-022 rd_en while empty SHALL be ignored (no pointer movement, no flag change).
REQ-023 Push and pop in the same cycle SHALL both take effect, count unchanged, including when full (no overflow) and when empty+push (push only).
REQ-024 Push when full without a simultaneous pop SHALL drop the new event, leave contents intact, and set ovf=1.
REQ-025 ovf SHALL stay set until ovf_clr=1; if ovf_clr and a new drop coincide, ovf SHALL remain 1.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count SHALL saturate at DEPTH by construction, never exceeding it.
REQ-027 When empty, ev_code/ev_break/ev_ext SHALL be 0.

Reset
REQ-028 reset=0 SHALL asynchronously force FSM=IDLE, skip counter=0, pointers=0, count=0, ev_valid=0, ev_code=0, ev_break=0, ev_ext=0, ovf=0.
REQ-029 Reset mid-sequence (after E0 or F0) SHALL discard the partial prefix; the next byte after release is decoded from IDLE.
REQ-030 Reset release SHALL take effect on the first clk edge after reset rises; no event is pushed on that edge from stale code.

Configuration
REQ-031 Macro KBD_TYPEMATIC_FILTER_EN SHALL compile in an auto-repeat filter: a make event identical ({code,ext}) to the last pushed make, with no intervening break of that key, is discarded (no push, no ovf).
REQ-032 With KBD_TYPEMATIC_FILTER_EN, a break event of the tracked key SHALL clear the tracker; reset clears the tracker.
REQ-033 Without KBD_TYPEMATIC_FILTER_EN, every decoded make SHALL be pushed, including repeats.

Structure
REQ-034 Package kbd_pkg SHALL hold the FSM state enum, constants PFX_EXT=8'hE0, PFX_BRK=8'hF0, PFX_PAUSE=8'hE1, PAUSE_SKIP_LEN=7, and the 10-bit event struct {ext,brk,code}.
REQ-035 Storage SHALL be a sub-module sync_fifo (parameterised width/depth, FWFT, full/empty/count); the decoder FSM and filter live in kbd_event_fifo.

Verification
REQ-036 Ticks 1C -> one event {1C,0,0}; ev_valid=1 one cycle after tick; rd_en -> ev_valid=0, count=0.
REQ-037 Ticks E0,F0,75 -> exactly one event {75,1,1}; ticks F0,1C -> {1C,1,0}.
REQ-038 DEPTH=8: push 9 makes with no reads -> count=8, ovf=1, head=first code; ovf_clr -> ovf=0.
REQ-039 Full FIFO, tick with rd_en same cycle -> count stays 8, ovf stays 0, new event at tail.
REQ-040 Ticks E1,14,77,E1,F0,14,F0,77 then 1C -> only {1C,0,0} queued; reset asserted after E0 then tick 1C -> {1C,0,0}.
REQ-041 With KBD_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C,1C -> events {1C,0},{1C,1},{1C,0}; without it -> 5 events.
